// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int unsigned DEF_NB_ADDR = 32;
  localparam int unsigned DEF_NB_DATA = 32;
  localparam int unsigned DEF_NB_PC   = 32;
  localparam int unsigned DEF_NB_REG  = 5;
  localparam int unsigned DEF_NB_CNT  = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STEP   = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic word_en;
    logic halfword_en;
    logic byte_en;
    logic branch;
    logic zero;
    logic r31_ctrl;
    logic hlt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE     = '0;
  // mem_to_reg only steers writeback muxing, so a bubble passes it through
  localparam ctrl_t CTRL_FLUSH_KEEP = '{mem_to_reg: 1'b1, default: 1'b0};

  function automatic ctrl_t bubble_ctrl(input ctrl_t c);
    return ctrl_t'((c & CTRL_FLUSH_KEEP) | (CTRL_BUBBLE & ~CTRL_FLUSH_KEEP));
  endfunction

endpackage

// File: rtl/ex_mem_latch_step_edge_detector.sv
// Registers the debug step request and flags its rising edge.
module step_edge_detector (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_step,
  output logic step_rise_c
);

  logic step_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) step_q <= 1'b0;
    else            step_q <= i_step;
  end

  assign step_rise_c = i_step & ~step_q;

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with run/step/halt advance control.
// Define EX_MEM_PERF_CNT_EN to build the cycle/instruction counters.
module ex_mem_latch
  import ex_mem_pkg::*;
#(
  parameter int unsigned NB_ADDR = DEF_NB_ADDR,
  parameter int unsigned NB_DATA = DEF_NB_DATA,
  parameter int unsigned NB_PC   = DEF_NB_PC,
  parameter int unsigned NB_REG  = DEF_NB_REG,
  parameter int unsigned NB_CNT  = DEF_NB_CNT
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic               i_flush,
  input  logic               i_EX_reg_write,
  input  logic               i_EX_mem_to_reg,
  input  logic               i_EX_mem_read,
  input  logic               i_EX_mem_write,
  input  logic               i_EX_word_en,
  input  logic               i_EX_halfword_en,
  input  logic               i_EX_byte_en,
  input  logic               i_EX_branch,
  input  logic               i_EX_zero,
  input  logic               i_EX_r31_ctrl,
  input  logic               i_EX_hlt,
  input  logic [NB_PC-1:0]   i_EX_branch_addr,
  input  logic [NB_PC-1:0]   i_EX_pc,
  input  logic [NB_ADDR-1:0] i_EX_alu_result,
  input  logic [NB_DATA-1:0] i_EX_write_data,
  input  logic [NB_REG-1:0]  i_EX_selected_reg,
  output logic               o_MEM_reg_write,
  output logic               o_MEM_mem_to_reg,
  output logic               o_MEM_mem_read,
  output logic               o_MEM_mem_write,
  output logic               o_MEM_word_en,
  output logic               o_MEM_halfword_en,
  output logic               o_MEM_byte_en,
  output logic               o_MEM_branch,
  output logic               o_MEM_zero,
  output logic               o_MEM_r31_ctrl,
  output logic               o_MEM_hlt,
  output logic [NB_PC-1:0]   o_MEM_branch_addr,
  output logic [NB_PC-1:0]   o_MEM_pc,
  output logic [NB_ADDR-1:0] o_MEM_alu_result,
  output logic [NB_DATA-1:0] o_MEM_write_data,
  output logic [NB_REG-1:0]  o_MEM_selected_reg,
  output logic               o_halted,
  output logic [NB_CNT-1:0]  o_cycle_count,
  output logic [NB_CNT-1:0]  o_instr_count
);

  state_e state, state_nxt;
  logic   advance_c;
  logic   step_rise_c;
  ctrl_t  ctrl_in, ctrl_d, ctrl_q;

  step_edge_detector u_step_edge (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_step      (i_step),
    .step_rise_c (step_rise_c)
  );

  assign ctrl_in = ctrl_t'({i_EX_reg_write, i_EX_mem_to_reg, i_EX_mem_read, i_EX_mem_write,
                            i_EX_word_en, i_EX_halfword_en, i_EX_byte_en, i_EX_branch,
                            i_EX_zero, i_EX_r31_ctrl, i_EX_hlt});
  assign ctrl_d  = i_flush ? bubble_ctrl(ctrl_in) : ctrl_in;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_RUN;
    else            state <= state_nxt;
  end

  // Advance decision and mode transitions; a latched, unflushed hlt wins over mode changes
  always_comb begin
    state_nxt = state;
    advance_c = 1'b0;
    unique case (state)
      ST_RUN: begin
        advance_c = i_enable;
        if (i_step_mode) state_nxt = ST_STEP;
      end
      ST_STEP: begin
        advance_c = i_enable & step_rise_c;
        if (!i_step_mode) state_nxt = ST_RUN;
      end
      default: ;
    endcase
    if (advance_c && ctrl_in.hlt && !i_flush) state_nxt = ST_HALTED;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl_q             <= CTRL_BUBBLE;
      o_MEM_branch_addr  <= '0;
      o_MEM_pc           <= '0;
      o_MEM_alu_result   <= '0;
      o_MEM_write_data   <= '0;
      o_MEM_selected_reg <= '0;
      o_halted           <= 1'b0;
    end else begin
      o_halted <= (state_nxt == ST_HALTED);
      if (advance_c) begin
        ctrl_q             <= ctrl_d;
        o_MEM_branch_addr  <= i_EX_branch_addr;
        o_MEM_pc           <= i_EX_pc;
        o_MEM_alu_result   <= i_EX_alu_result;
        o_MEM_write_data   <= i_EX_write_data;
        o_MEM_selected_reg <= i_EX_selected_reg;
      end
    end
  end

  assign o_MEM_reg_write   = ctrl_q.reg_write;
  assign o_MEM_mem_to_reg  = ctrl_q.mem_to_reg;
  assign o_MEM_mem_read    = ctrl_q.mem_read;
  assign o_MEM_mem_write   = ctrl_q.mem_write;
  assign o_MEM_word_en     = ctrl_q.word_en;
  assign o_MEM_halfword_en = ctrl_q.halfword_en;
  assign o_MEM_byte_en     = ctrl_q.byte_en;
  assign o_MEM_branch      = ctrl_q.branch;
  assign o_MEM_zero        = ctrl_q.zero;
  assign o_MEM_r31_ctrl    = ctrl_q.r31_ctrl;
  assign o_MEM_hlt         = ctrl_q.hlt;

`ifdef EX_MEM_PERF_CNT_EN
  logic [NB_CNT-1:0] cycle_q, instr_q;

  // Bubbles count as cycles but not as instructions
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (advance_c) begin
      cycle_q <= cycle_q + NB_CNT'(1);
      if (!i_flush) instr_q <= instr_q + NB_CNT'(1);
    end
  end

  assign o_cycle_count = cycle_q;
  assign o_instr_count = instr_q;
`else
  assign o_cycle_count = '0;
  assign o_instr_count = '0;
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// Randomised bench for ex_mem_latch against a behavioural advance/halt model.
module tb_ex_mem_latch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en = 1'b0, smode = 1'b0, step = 1'b0, flush = 1'b0;
  // bit order: 10 reg_write, 9 mem_to_reg, 8 mem_read, 7 mem_write, 6 word, 5 half, 4 byte,
  //            3 branch, 2 zero, 1 r31_ctrl, 0 hlt
  logic [10:0] c = '0;
  logic [31:0] baddr = '0, pc = '0, alu = '0, wd = '0;
  logic [4:0]  sel = '0;

  logic        o_rw, o_mtr, o_mr, o_mw, o_we, o_he, o_be, o_br, o_z, o_r31, o_hlt, o_halted;
  logic [31:0] o_baddr, o_pc, o_alu, o_wd, o_cyc, o_ins;
  logic [4:0]  o_sel;

  ex_mem_latch dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_step_mode(smode), .i_step(step),
    .i_flush(flush),
    .i_EX_reg_write(c[10]), .i_EX_mem_to_reg(c[9]), .i_EX_mem_read(c[8]), .i_EX_mem_write(c[7]),
    .i_EX_word_en(c[6]), .i_EX_halfword_en(c[5]), .i_EX_byte_en(c[4]), .i_EX_branch(c[3]),
    .i_EX_zero(c[2]), .i_EX_r31_ctrl(c[1]), .i_EX_hlt(c[0]),
    .i_EX_branch_addr(baddr), .i_EX_pc(pc), .i_EX_alu_result(alu), .i_EX_write_data(wd),
    .i_EX_selected_reg(sel),
    .o_MEM_reg_write(o_rw), .o_MEM_mem_to_reg(o_mtr), .o_MEM_mem_read(o_mr),
    .o_MEM_mem_write(o_mw), .o_MEM_word_en(o_we), .o_MEM_halfword_en(o_he),
    .o_MEM_byte_en(o_be), .o_MEM_branch(o_br), .o_MEM_zero(o_z), .o_MEM_r31_ctrl(o_r31),
    .o_MEM_hlt(o_hlt), .o_MEM_branch_addr(o_baddr), .o_MEM_pc(o_pc),
    .o_MEM_alu_result(o_alu), .o_MEM_write_data(o_wd), .o_MEM_selected_reg(o_sel),
    .o_halted(o_halted), .o_cycle_count(o_cyc), .o_instr_count(o_ins)
  );

  // Reference model state
  bit          m_halted, m_step, m_prev;
  logic [10:0] e_c;
  logic [31:0] e_baddr, e_pc, e_alu, e_wd, e_cyc, e_ins;
  logic [4:0]  e_sel;
  int          n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] cnt_exp;
`ifdef EX_MEM_PERF_CNT_EN
    cnt_exp = {e_cyc, e_ins};
`else
    cnt_exp = '0;
`endif
    check({tag, ":ctrl"}, 128'({o_rw, o_mtr, o_mr, o_mw, o_we, o_he, o_be, o_br, o_z, o_r31, o_hlt}),
          128'(e_c));
    check({tag, ":pcs"}, 128'({o_baddr, o_pc}), 128'({e_baddr, e_pc}));
    check({tag, ":data"}, 128'({o_alu, o_wd, o_sel}), 128'({e_alu, e_wd, e_sel}));
    check({tag, ":halted"}, 128'(o_halted), 128'(m_halted));
    check({tag, ":counters"}, 128'({o_cyc, o_ins}), 128'(cnt_exp));
  endtask

  task automatic model_reset();
    m_halted = 1'b0; m_step = 1'b0; m_prev = 1'b0;
    e_c = '0; e_baddr = '0; e_pc = '0; e_alu = '0; e_wd = '0; e_sel = '0;
    e_cyc = '0; e_ins = '0;
  endtask

  // Predict the effect of the coming rising edge, take it, then compare
  task automatic tick(input string tag);
    bit adv;
    adv = !m_halted && en && (!m_step || (step && !m_prev));
    if (adv) begin
      e_c = flush ? (c & 11'b010_0000_0000) : c;
      e_baddr = baddr; e_pc = pc; e_alu = alu; e_wd = wd; e_sel = sel;
      e_cyc++;
      if (!flush) e_ins++;
    end
    if (!m_halted) begin
      if (adv && c[0] && !flush) m_halted = 1'b1;
      else m_step = smode;
    end
    m_prev = step;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges, checked before any edge, released on a falling edge
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    baddr = $urandom; pc = $urandom; alu = $urandom; wd = $urandom; sel = 5'($urandom);
  endtask

  task automatic rand_inputs(input bit allow_hlt);
    en    = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 7) == 0) smode = ~smode;
    step  = 1'($urandom);
    flush = ($urandom_range(0, 3) == 0);
    c     = 11'($urandom);
    c[0]  = allow_hlt && ($urandom_range(0, 15) == 0);
    rand_data();
  endtask

  initial begin
    logic [31:0] held_pc;
    int          pc_changes;

    model_reset();
    #7;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic RUN capture; outputs still zero the cycle before
    en = 1'b1; c = 11'b100_0000_0000; alu = 32'h10;
    check_all("pre_capture");
    tick("capture");
    check("capture_alu", 128'(o_alu), 128'(32'h10));
    check("capture_rw", 128'(o_rw), 128'(1'b1));

    // flush turns a store into a bubble, datapath still loads
    c = 11'b000_1000_0000; alu = 32'h24; flush = 1'b1;
    tick("flush");
    check("flush_mw", 128'(o_mw), 128'(1'b0));
    check("flush_alu", 128'(o_alu), 128'(32'h24));

    // flushed hlt must not halt
    c = 11'b000_0000_0001; pc = 32'h100;
    tick("flush_hlt");
    check("flush_hlt_o", 128'({o_hlt, o_halted}), 128'(2'b00));
    flush = 1'b0; c = '0; pc = 32'h104;
    tick("after_flush_hlt");
    check("keeps_running", 128'(o_pc), 128'(32'h104));

    // step mode: held step gives one advance, re-raise gives a second
    smode = 1'b1; step = 1'b0; pc = 32'h200;
    tick("enter_step");
    step = 1'b1; pc_changes = 0;
    for (int i = 0; i < 5; i++) begin
      held_pc = o_pc;
      pc = 32'h300 + 32'(i);
      tick("step_held");
      if (o_pc !== held_pc) pc_changes++;
    end
    check("one_advance", 128'(pc_changes), 128'(1));
    check("one_advance_pc", 128'(o_pc), 128'(32'h300));
    step = 1'b0; pc = 32'h400;
    tick("step_low");
    step = 1'b1; pc = 32'h404;
    tick("step_rise2");
    check("second_advance", 128'(o_pc), 128'(32'h404));

    // reset in step mode with live outputs
    c = 11'h7FE; rand_data();
    step = 1'b0;
    tick("pre_rst");
    step = 1'b1;
    tick("pre_rst2");
    async_reset("rst_in_step");
    smode = 1'b0; step = 1'b0; c = 11'b100_0000_0000; pc = 32'h500;
    tick("run_after_rst");
    check("run_after_rst_pc", 128'(o_pc), 128'(32'h500));

    // halt freezes everything until reset
    c = 11'b000_0000_0001; pc = 32'h600;
    tick("hlt");
    check("hlt_visible", 128'({o_hlt, o_halted}), 128'(2'b11));
    for (int i = 0; i < 8; i++) begin
      rand_inputs(1'b1);
      step = 1'(i);
      tick("halted");
      check("halted_pc", 128'(o_pc), 128'(32'h600));
    end
    async_reset("rst_halted");

    // randomised mix including occasional hlt and resets
    for (int i = 0; i < 600; i++) begin
      rand_inputs(1'b1);
      if (i % 60 == 59) async_reset("rand_rst");
      else tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
